// File: rtl/pwm_meter_pkg.sv
// Shared definitions for the PWM generator / meter pair.
package pwm_pkg;

   localparam int PWM_N = 8;

   typedef enum logic [1:0] {
      PWM_IDLE = 2'd0,
      PWM_HIGH = 2'd1,
      PWM_LOW  = 2'd2
   } pwm_state_e;

endpackage

// File: rtl/pwm_meter_if.sv
// PWM input and measurement outputs of pwm_meter; the meter is the slave side.
interface pwm_meter_if
   import pwm_pkg::*;
#(
   parameter int N = PWM_N
);
   logic         i_pwm;
   logic [N-1:0] o_period;
   logic [N-1:0] o_htime;
   logic         o_valid;
   logic         o_timeout;

   modport slave  (input  i_pwm, output o_period, o_htime, o_valid, o_timeout);
   modport master (output i_pwm, input  o_period, o_htime, o_valid, o_timeout);
endinterface

// File: rtl/pwm_meter_sync_edge.sv
// Multi-flop synchronizer for an external pin with rise/fall detection on the
// synchronized level.
module sync_edge #(
   parameter int SYNC = 2
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);
   logic [SYNC-1:0] sync_q;
   logic            level_d;

   if (SYNC < 2) begin : g_bad_sync
      $error("sync_edge: SYNC must be at least 2");
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync_q  <= '0;
         level_d <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC-2:0], i_async};
         level_d <= sync_q[SYNC-1];
      end
   end

   assign o_level = sync_q[SYNC-1];
   assign o_rise  = sync_q[SYNC-1] & ~level_d;
   assign o_fall  = ~sync_q[SYNC-1] & level_d;
endmodule

// File: rtl/pwm_meter.sv
// Measures period and high time of an asynchronous PWM input in sys_clk cycles,
// with a timeout flag when the input stops toggling.
module pwm_meter
   import pwm_pkg::*;
#(
   parameter int N    = PWM_N,
   parameter int SYNC = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   pwm_meter_if.slave bus
);
   localparam logic [N-1:0] CNT_MAX = '1;
   localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

   pwm_state_e   state;
   logic [N-1:0] cnt;
   logic [N-1:0] htime_r;
   logic         rise;
   logic         fall;
   logic         sat;
   logic         level_unused;

   sync_edge #(.SYNC(SYNC)) u_sync (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .i_async (bus.i_pwm),
      .o_level (level_unused),
      .o_rise  (rise),
      .o_fall  (fall)
   );

   // Saturating counter: a stuck input parks it at all-ones instead of wrapping.
   assign sat = (cnt == CNT_MAX);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt <= '0;
      end else if (rise) begin
         cnt <= CNT_ONE;
      end else if (!sat) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state         <= PWM_IDLE;
         htime_r       <= '0;
         bus.o_period  <= '0;
         bus.o_htime   <= '0;
         bus.o_valid   <= 1'b0;
         bus.o_timeout <= 1'b0;
      end else begin
         bus.o_valid <= 1'b0;
         case (state)
            PWM_IDLE: begin
               if (rise) state <= PWM_HIGH;
            end
            PWM_HIGH: begin
               if (sat) begin
                  bus.o_timeout <= 1'b1;
                  state         <= PWM_IDLE;
               end else if (fall) begin
                  htime_r <= cnt;
                  state   <= PWM_LOW;
               end
            end
            PWM_LOW: begin
               // A rise in the saturation cycle still closes a valid period.
               if (rise) begin
                  bus.o_period  <= cnt;
                  bus.o_htime   <= htime_r;
                  bus.o_valid   <= 1'b1;
                  bus.o_timeout <= 1'b0;
                  state         <= PWM_HIGH;
               end else if (sat) begin
                  bus.o_timeout <= 1'b1;
                  state         <= PWM_IDLE;
               end
            end
            default: state <= PWM_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pwm_meter.sv
// Bench for pwm_meter: PWM stimulus against an edge-timestamp reference model.
module tb_pwm_meter;
   import pwm_pkg::*;

   localparam int N    = PWM_N;
   localparam int SYNC = 2;
   localparam int MAXC = (1 << N) - 1;

   logic clk;
   logic rst;
   pwm_meter_if #(.N(N)) bif ();

   pwm_meter #(.N(N), .SYNC(SYNC)) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Stimulus generator state
   int gen_mode = 1;   // 0 periodic, 1 constant low, 2 constant high
   int gen_p    = 10;
   int gen_h    = 3;
   int ph       = 0;

   // Reference model: timestamps of raw edges, outputs delayed by SYNC edges
   int           e      = 0;
   int           r_edge = 0;
   int           f_edge = -1;
   bit           armed  = 0;
   logic         xp     = 1'b0;
   logic         mv     = 1'b0;
   logic         mt     = 1'b0;
   logic [N-1:0] mp     = '0;
   logic [N-1:0] mh     = '0;
   logic [2*N+1:0] dly [0:SYNC];

   logic [2*N+1:0] got;
   assign got = {bif.o_valid, bif.o_timeout, bif.o_period, bif.o_htime};

   int           n_valid = 0;
   logic [N-1:0] last_p  = '0;
   logic [N-1:0] last_h  = '0;

   always @(negedge clk) begin
      if (bif.o_valid === 1'b1) begin
         n_valid++;
         last_p = bif.o_period;
         last_h = bif.o_htime;
      end
   end

   task automatic model_reset();
      armed = 0; xp = 1'b0; mv = 1'b0; mt = 1'b0; mp = '0; mh = '0;
      f_edge = -1;
      for (int k = 0; k <= SYNC; k++) dly[k] = '0;
   endtask

   task automatic model_step();
      logic x, rise, fall;
      if (rst) return;
      x = bif.i_pwm;
      e++;
      rise = x & ~xp;
      fall = ~x & xp;
      xp   = x;
      mv   = 1'b0;
      if (armed) begin
         if (f_edge < 0) begin
            if (e - r_edge == MAXC) begin armed = 0; mt = 1'b1; end
            else if (fall) f_edge = e;
         end else begin
            if (rise) begin
               mv = 1'b1; mt = 1'b0;
               mp = N'(e - r_edge);
               mh = N'(f_edge - r_edge);
               r_edge = e; f_edge = -1;
            end else if (e - r_edge == MAXC) begin
               armed = 0; mt = 1'b1;
            end
         end
      end else if (rise) begin
         armed = 1; r_edge = e; f_edge = -1;
      end
      for (int k = SYNC; k > 0; k--) dly[k] = dly[k-1];
      dly[0] = {mv, mt, mp, mh};
   endtask

   // One clock: model samples with the DUT, then the next PWM level is driven.
   task automatic pwm_tick();
      @(posedge clk);
      model_step();
      #1;
      if (gen_mode == 0) begin
         ph = (ph + 1 >= gen_p) ? 0 : ph + 1;
         bif.i_pwm = (ph < gen_h);
      end else begin
         bif.i_pwm = (gen_mode == 2);
      end
   endtask

   task automatic set_pwm(input int p, input int h);
      gen_mode = 0; gen_p = p; gen_h = h;
   endtask

   task automatic test_reset();
      rst = 1'b1; bif.i_pwm = 1'b0; gen_mode = 1;
      model_reset();
      #3;
      n_chk++;
      if (got !== '0) begin n_fail++; $display("FAIL reset_async: got %h required 0", got); end
      repeat (4) begin
         pwm_tick(); @(negedge clk);
         n_chk++;
         if (got !== '0) begin n_fail++; $display("FAIL reset_hold: got %h required 0", got); end
      end
      #2 rst = 1'b0;
   endtask

   task automatic test_loopback();
      int n0;
      set_pwm(10, 3); ph = 9; n0 = n_valid;
      repeat (80) begin
         pwm_tick(); @(negedge clk);
         n_chk++;
         if (got !== dly[SYNC]) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL loopback (valid,to,per,ht): got %h required %h", got, dly[SYNC]);
         end
      end
      #1;
      n_chk++;
      if (n_valid - n0 < 6) begin n_fail++; $display("FAIL loopback_count: got %0d required >=6", n_valid - n0); end
      n_chk++;
      if ({last_p, last_h, bif.o_timeout} !== {8'd10, 8'd3, 1'b0}) begin
         n_fail++; $display("FAIL loopback_value: got %0d/%0d to=%b required 10/3 to=0", last_p, last_h, bif.o_timeout);
      end
   endtask

   task automatic test_duty_change();
      int ps[3] = '{7, 6, 4};
      int hs[3] = '{5, 5, 1};
      for (int i = 0; i < 3; i++) begin
         set_pwm(ps[i], hs[i]);
         repeat (45) begin
            pwm_tick(); @(negedge clk);
            n_chk++;
            if (got !== dly[SYNC]) begin
               n_fail++;
               if (n_fail <= 20) $display("FAIL duty_change (valid,to,per,ht): got %h required %h", got, dly[SYNC]);
            end
         end
         #1;
         n_chk++;
         if (last_p !== N'(ps[i]) || last_h !== N'(hs[i])) begin
            n_fail++; $display("FAIL duty_value: got %0d/%0d required %0d/%0d", last_p, last_h, ps[i], hs[i]);
         end
      end
   endtask

   task automatic test_random();
      int p, h;
      repeat (6) begin
         p = int'($urandom_range(60, 2));
         h = int'($urandom_range(p - 1, 1));
         set_pwm(p, h);
         repeat (3 * p + 12) begin
            pwm_tick(); @(negedge clk);
            n_chk++;
            if (got !== dly[SYNC]) begin
               n_fail++;
               if (n_fail <= 20) $display("FAIL random p=%0d h=%0d (valid,to,per,ht): got %h required %h", p, h, got, dly[SYNC]);
            end
         end
         #1;
         n_chk++;
         if (last_p !== N'(p) || last_h !== N'(h)) begin
            n_fail++; $display("FAIL random_value: got %0d/%0d required %0d/%0d", last_p, last_h, p, h);
         end
      end
   endtask

   task automatic test_timeout();
      int hp, hh;
      hp = gen_p; hh = gen_h;
      gen_mode = 1;
      repeat (300) begin
         pwm_tick(); @(negedge clk);
         n_chk++;
         if (got !== dly[SYNC]) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL timeout_low (valid,to,per,ht): got %h required %h", got, dly[SYNC]);
         end
      end
      n_chk++;
      if (bif.o_timeout !== 1'b1 || bif.o_period !== N'(hp) || bif.o_htime !== N'(hh)) begin
         n_fail++; $display("FAIL timeout_hold: got to=%b %0d/%0d required to=1 %0d/%0d", bif.o_timeout, bif.o_period, bif.o_htime, hp, hh);
      end
      set_pwm(10, 3); ph = 9;
      repeat (40) begin
         pwm_tick(); @(negedge clk);
         n_chk++;
         if (got !== dly[SYNC]) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL timeout_resume (valid,to,per,ht): got %h required %h", got, dly[SYNC]);
         end
      end
      n_chk++;
      if (bif.o_timeout !== 1'b0 || last_p !== 8'd10 || last_h !== 8'd3) begin
         n_fail++; $display("FAIL timeout_clear: got to=%b %0d/%0d required to=0 10/3", bif.o_timeout, last_p, last_h);
      end
   endtask

   task automatic test_const_high();
      int n0;
      gen_mode = 2;
      n0 = n_valid;
      for (int i = 0; i < 300; i++) begin
         if (i == 20) n0 = n_valid;
         pwm_tick(); @(negedge clk);
         n_chk++;
         if (got !== dly[SYNC]) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL const_high (valid,to,per,ht): got %h required %h", got, dly[SYNC]);
         end
      end
      #1;
      n_chk++;
      if (n_valid != n0 || bif.o_timeout !== 1'b1) begin
         n_fail++; $display("FAIL const_high_state: got %0d strobes to=%b required 0 strobes to=1", n_valid - n0, bif.o_timeout);
      end
   endtask

   task automatic test_reset_mid();
      int n0;
      set_pwm(10, 3); ph = 9;
      repeat (30) pwm_tick();
      for (int i = 0; i < 12 && bif.i_pwm !== 1'b1; i++) pwm_tick();
      pwm_tick();
      #2 rst = 1'b1;
      model_reset();
      #1;
      n_chk++;
      if (got !== '0) begin n_fail++; $display("FAIL reset_mid_async: got %h required 0", got); end
      repeat (2) @(posedge clk);
      #4 rst = 1'b0;
      n0 = n_valid;
      repeat (45) begin
         pwm_tick(); @(negedge clk);
         n_chk++;
         if (got !== dly[SYNC]) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL reset_mid (valid,to,per,ht): got %h required %h", got, dly[SYNC]);
         end
      end
      #1;
      n_chk++;
      if (n_valid - n0 < 2 || last_p !== 8'd10 || last_h !== 8'd3) begin
         n_fail++; $display("FAIL reset_mid_value: got %0d strobes %0d/%0d required >=2 strobes 10/3", n_valid - n0, last_p, last_h);
      end
   endtask

   task automatic test_max_value();
      set_pwm(254, 1); ph = 253;
      repeat (254 * 3 + 20) begin
         pwm_tick(); @(negedge clk);
         n_chk++;
         if (got !== dly[SYNC]) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL max_value (valid,to,per,ht): got %h required %h", got, dly[SYNC]);
         end
      end
      #1;
      n_chk++;
      if (last_p !== 8'd254 || last_h !== 8'd1 || bif.o_timeout !== 1'b0) begin
         n_fail++; $display("FAIL max_value_final: got %0d/%0d to=%b required 254/1 to=0", last_p, last_h, bif.o_timeout);
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_duty_change();
      test_random();
      test_timeout();
      test_const_high();
      test_reset_mid();
      test_max_value();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
